// File: rtl/gather_two_if.sv
// Symbol-in / byte-out bundle for gather_two: the slave modport is the
// assembler side and the master modport is the symbol source / byte consumer.
interface gather_two_if;
  logic [1:0] sym_in;
  logic       sym_valid;
  logic       sym_first;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ack;
  logic       overrun;
  logic       frame_err;

  modport master (
    output sym_in, sym_valid, sym_first, data_ack,
    input  data_out, data_valid, overrun, frame_err
  );

  modport slave (
    input  sym_in, sym_valid, sym_first, data_ack,
    output data_out, data_valid, overrun, frame_err
  );
endinterface

// File: rtl/gather_two.sv
// Gathers four MSB-first dibits into a byte with a single-entry output holding register.
// Optional partial-byte idle timeout is enabled by defining GATHER_TWO_TIMEOUT_EN.
module gather_two #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  gather_two_if.slave bus
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] sym_cnt_q, sym_cnt_d;
  logic [5:0] shift_q, shift_d;
  logic [7:0] data_out_q, data_out_d;
  logic       data_valid_q, data_valid_d;
  logic       overrun_q, overrun_d;
  logic       frame_err_q, frame_err_d;

  logic       restart_s;
  logic       complete_s;
  logic       timeout_s;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("gather_two: TIMEOUT_CYCLES must be within 2..255");
  end

  // Classify the current edge: resync restart or byte completion.
  always_comb begin
    restart_s  = 1'b0;
    complete_s = 1'b0;
    if (state_q == ST_COLLECT && bus.sym_valid) begin
      restart_s  = bus.sym_first;
      complete_s = !bus.sym_first && (sym_cnt_q == 2'd3);
    end else begin
      restart_s  = 1'b0;
      complete_s = 1'b0;
    end
  end

`ifdef GATHER_TWO_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] tmo_cnt_q, tmo_cnt_d;

  // Idle-cycle counter; only runs while a partial byte is held.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    timeout_s = 1'b0;
    if (state_q == ST_COLLECT && !bus.sym_valid) begin
      if (tmo_cnt_q == TMO_LAST) begin
        timeout_s = 1'b1;
        tmo_cnt_d = 8'd0;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 8'd1;
      end
    end else begin
      tmo_cnt_d = 8'd0;
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= 8'd0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.sym_valid) begin
          state_d = ST_COLLECT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (complete_s || timeout_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath and output-pulse decode.
  always_comb begin
    shift_d     = shift_q;
    sym_cnt_d   = sym_cnt_q;
    data_out_d  = data_out_q;
    overrun_d   = 1'b0;
    frame_err_d = 1'b0;
    if (complete_s) begin
      data_out_d = {shift_q, bus.sym_in};
      overrun_d  = data_valid_q & ~bus.data_ack;
      shift_d    = 6'd0;
      sym_cnt_d  = 2'd0;
    end else if (bus.sym_valid && (state_q == ST_IDLE || restart_s)) begin
      // Any symbol seen without a partial byte, or a resync, starts a new byte.
      shift_d     = {4'b0000, bus.sym_in};
      sym_cnt_d   = 2'd1;
      frame_err_d = restart_s;
    end else if (bus.sym_valid) begin
      shift_d   = {shift_q[3:0], bus.sym_in};
      sym_cnt_d = sym_cnt_q + 2'd1;
    end else if (timeout_s) begin
      shift_d     = 6'd0;
      sym_cnt_d   = 2'd0;
      frame_err_d = 1'b1;
    end else begin
      shift_d   = shift_q;
      sym_cnt_d = sym_cnt_q;
    end

    if (complete_s) begin
      data_valid_d = 1'b1;
    end else if (bus.data_ack) begin
      data_valid_d = 1'b0;
    end else begin
      data_valid_d = data_valid_q;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sym_cnt_q    <= 2'd0;
      shift_q      <= 6'd0;
      data_out_q   <= 8'h00;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      sym_cnt_q    <= sym_cnt_d;
      shift_q      <= shift_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.overrun    = overrun_q;
  assign bus.frame_err  = frame_err_q;

endmodule

// File: tb/tb_gather_two.sv
// Self-checking bench for gather_two: expected bytes queued when driven, popped when produced.
module tb_gather_two;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gather_two_if bus();

  gather_two #(.TIMEOUT_CYCLES(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_b;

  always @(negedge clk) begin
    if (bus.frame_err === 1'b1) fe_cnt++;
    if (bus.overrun === 1'b1) ov_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic put(input logic [1:0] s, input logic f, input logic a);
    @(negedge clk);
    bus.sym_in = s; bus.sym_valid = 1'b1; bus.sym_first = f; bus.data_ack = a;
  endtask

  task automatic idle(input logic a);
    @(negedge clk);
    bus.sym_in = 2'b00; bus.sym_valid = 1'b0; bus.sym_first = 1'b0; bus.data_ack = a;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic ack_last);
    put(b[7:6], 1'b1, 1'b0);
    put(b[5:4], 1'b0, 1'b0);
    put(b[3:2], 1'b0, 1'b0);
    put(b[1:0], 1'b0, ack_last);
    exp_q.push_back(b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.sym_in = 2'b00; bus.sym_valid = 1'b0; bus.sym_first = 1'b0; bus.data_ack = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.data_out !== 8'h00) begin n_errors++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
    n_checks++; if (bus.data_valid !== 1'b0) begin n_errors++; $display("FAIL reset_data_valid: got %b expected 0", bus.data_valid); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    n_checks++; if (bus.frame_err !== 1'b0) begin n_errors++; $display("FAIL reset_frame_err: got %b expected 0", bus.frame_err); end
    rst = 1'b0;
  endtask

  task automatic test_assemble();
    put(2'b01, 1'b1, 1'b0);
    put(2'b10, 1'b0, 1'b0);
    put(2'b11, 1'b0, 1'b0);
    n_checks++; if (bus.data_valid !== 1'b0) begin n_errors++; $display("FAIL assemble_early_valid: got %b expected 0", bus.data_valid); end
    put(2'b00, 1'b0, 1'b0);
    exp_q.push_back(8'h6C);
    idle(1'b0);
    exp_b = exp_q.pop_front();
    n_checks++; if (bus.data_out !== exp_b) begin n_errors++; $display("FAIL assemble_data: got %h expected %h", bus.data_out, exp_b); end
    n_checks++; if (bus.data_valid !== 1'b1) begin n_errors++; $display("FAIL assemble_valid: got %b expected 1", bus.data_valid); end
    idle(1'b0); idle(1'b0);
    n_checks++; if (bus.data_out !== exp_b || bus.data_valid !== 1'b1) begin n_errors++; $display("FAIL assemble_hold: got %h/%b expected %h/1", bus.data_out, bus.data_valid, exp_b); end
    idle(1'b1); idle(1'b0);
    n_checks++; if (bus.data_valid !== 1'b0) begin n_errors++; $display("FAIL assemble_ack_clear: got %b expected 0", bus.data_valid); end
  endtask

  task automatic test_overrun();
    send_byte(8'h6C, 1'b0);
    idle(1'b0);
    exp_b = exp_q.pop_front();
    n_checks++; if (bus.data_out !== exp_b) begin n_errors++; $display("FAIL overrun_first: got %h expected %h", bus.data_out, exp_b); end
    send_byte(8'hA5, 1'b0);
    idle(1'b0);
    exp_b = exp_q.pop_front();
    n_checks++; if (bus.data_out !== exp_b || bus.data_valid !== 1'b1) begin n_errors++; $display("FAIL overrun_data: got %h/%b expected %h/1", bus.data_out, bus.data_valid, exp_b); end
    n_checks++; if (bus.overrun !== 1'b1) begin n_errors++; $display("FAIL overrun_pulse: got %b expected 1", bus.overrun); end
    idle(1'b0);
    n_checks++; if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL overrun_single: got %b expected 0", bus.overrun); end
    idle(1'b1); idle(1'b0);
  endtask

  task automatic test_resync();
    int fe0;
    fe0 = fe_cnt;
    put(2'b11, 1'b1, 1'b0);
    put(2'b11, 1'b0, 1'b0);
    send_byte(8'h1B, 1'b0);
    idle(1'b0);
    exp_b = exp_q.pop_front();
    n_checks++; if (bus.data_out !== exp_b || bus.data_valid !== 1'b1) begin n_errors++; $display("FAIL resync_data: got %h/%b expected %h/1", bus.data_out, bus.data_valid, exp_b); end
    idle(1'b0); idle(1'b0);
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_errors++; $display("FAIL resync_frame_err: got %0d pulses expected 1", fe_cnt - fe0); end
    idle(1'b1); idle(1'b0);
  endtask

  task automatic test_ack_coincide();
    int ov0;
    send_byte(8'h6C, 1'b0);
    idle(1'b0);
    exp_b = exp_q.pop_front();
    n_checks++; if (bus.data_out !== exp_b) begin n_errors++; $display("FAIL coincide_pending: got %h expected %h", bus.data_out, exp_b); end
    ov0 = ov_cnt;
    send_byte(8'hFF, 1'b1);
    idle(1'b0);
    exp_b = exp_q.pop_front();
    n_checks++; if (bus.data_out !== exp_b || bus.data_valid !== 1'b1) begin n_errors++; $display("FAIL coincide_data: got %h/%b expected %h/1", bus.data_out, bus.data_valid, exp_b); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL coincide_overrun: got %b expected 0", bus.overrun); end
    idle(1'b1); idle(1'b0);
    n_checks++; if (bus.data_valid !== 1'b0 || ov_cnt !== ov0) begin n_errors++; $display("FAIL coincide_clear: got valid %b overruns %0d expected 0/%0d", bus.data_valid, ov_cnt, ov0); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3];
    int ov0;
    bytes[0] = 8'h3C; bytes[1] = 8'hC3; bytes[2] = 8'h5A;
    ov0 = ov_cnt;
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 4; k++) begin
        put(bytes[i][7 - 2*k -: 2], k == 0, (k == 3) && (i > 0));
        if (k == 0 && i > 0) begin
          exp_b = exp_q.pop_front();
          n_checks++; if (bus.data_out !== exp_b || bus.data_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_byte%0d: got %h/%b expected %h/1", i - 1, bus.data_out, bus.data_valid, exp_b); end
        end
        if (k == 3) exp_q.push_back(bytes[i]);
      end
    end
    idle(1'b1);
    exp_b = exp_q.pop_front();
    n_checks++; if (bus.data_out !== exp_b || bus.data_valid !== 1'b1) begin n_errors++; $display("FAIL b2b_last: got %h/%b expected %h/1", bus.data_out, bus.data_valid, exp_b); end
    idle(1'b0); idle(1'b0);
    n_checks++; if (bus.data_valid !== 1'b0 || ov_cnt !== ov0) begin n_errors++; $display("FAIL b2b_end: got valid %b overruns %0d expected 0/%0d", bus.data_valid, ov_cnt, ov0); end
  endtask

  task automatic test_gap();
    int fe0;
    fe0 = fe_cnt;
    put(2'b10, 1'b1, 1'b0); idle(1'b0); idle(1'b0);
    put(2'b01, 1'b0, 1'b0); idle(1'b0);
    put(2'b11, 1'b0, 1'b0); idle(1'b0); idle(1'b0); idle(1'b0);
    put(2'b00, 1'b0, 1'b0);
    exp_q.push_back(8'h9C);
    idle(1'b0);
    exp_b = exp_q.pop_front();
    n_checks++; if (bus.data_out !== exp_b || bus.data_valid !== 1'b1) begin n_errors++; $display("FAIL gap_data: got %h/%b expected %h/1", bus.data_out, bus.data_valid, exp_b); end
    idle(1'b1); idle(1'b0);
    n_checks++; if (fe_cnt !== fe0) begin n_errors++; $display("FAIL gap_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_timeout();
    int fe0;
    fe0 = fe_cnt;
`ifdef GATHER_TWO_TIMEOUT_EN
    put(2'b10, 1'b1, 1'b0);
    put(2'b01, 1'b0, 1'b0);
    repeat (64) idle(1'b0);
    idle(1'b0); idle(1'b0);
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_errors++; $display("FAIL timeout_frame_err: got %0d pulses expected 1", fe_cnt - fe0); end
    put(2'b00, 1'b0, 1'b0);
    put(2'b00, 1'b0, 1'b0);
    put(2'b00, 1'b0, 1'b0);
    put(2'b01, 1'b0, 1'b0);
    exp_q.push_back(8'h01);
`else
    put(2'b11, 1'b1, 1'b0);
    put(2'b01, 1'b0, 1'b0);
    repeat (70) idle(1'b0);
    n_checks++; if (fe_cnt !== fe0 || bus.data_valid !== 1'b0) begin n_errors++; $display("FAIL hold_partial: got %0d pulses valid %b expected 0/0", fe_cnt - fe0, bus.data_valid); end
    put(2'b10, 1'b0, 1'b0);
    put(2'b00, 1'b0, 1'b0);
    exp_q.push_back(8'hD8);
`endif
    idle(1'b0);
    exp_b = exp_q.pop_front();
    n_checks++; if (bus.data_out !== exp_b || bus.data_valid !== 1'b1) begin n_errors++; $display("FAIL timeout_next_byte: got %h/%b expected %h/1", bus.data_out, bus.data_valid, exp_b); end
    idle(1'b1); idle(1'b0);
  endtask

  task automatic test_reset_mid();
    int fe0;
    fe0 = fe_cnt;
    send_byte(8'h3C, 1'b0);
    put(2'b10, 1'b1, 1'b0);
    put(2'b11, 1'b0, 1'b0);
    put(2'b01, 1'b0, 1'b0);
    @(negedge clk);
    bus.sym_valid = 1'b0;
    rst = 1'b1;
    #1;
    exp_b = exp_q.pop_front();
    n_checks++; if (bus.data_valid !== 1'b0 || bus.data_out !== 8'h00) begin n_errors++; $display("FAIL async_reset: got %h/%b expected 00/0 (pending %h dropped)", bus.data_out, bus.data_valid, exp_b); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) put(2'b10, 1'b0, 1'b0);
    exp_q.push_back(8'hAA);
    idle(1'b0);
    exp_b = exp_q.pop_front();
    n_checks++; if (bus.data_out !== exp_b || bus.data_valid !== 1'b1) begin n_errors++; $display("FAIL reset_mid_data: got %h/%b expected %h/1", bus.data_out, bus.data_valid, exp_b); end
    idle(1'b1); idle(1'b0);
    n_checks++; if (fe_cnt !== fe0) begin n_errors++; $display("FAIL reset_mid_frame_err: got %0d pulses expected 0", fe_cnt - fe0); end
  endtask

  initial begin
    test_reset();
    test_assemble();
    test_overrun();
    test_resync();
    test_ack_coincide();
    test_back_to_back();
    test_gap();
    test_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gather_two.md
GATHER_TWO -- requirements
Module: gather_two

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 64, idle clk cycles after the last accepted symbol before a partial byte is discarded; legal range 2..255.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 sym_in  input  2  received symbol (one dibit).
REQ-005 sym_valid  input  1  sym_in is valid this cycle; a symbol is accepted on each clk edge where sym_valid=1.
REQ-006 sym_first  input  1  qualifies sym_in as the first (MSB) dibit of a byte; ignored when sym_valid=0.
REQ-007 data_out  output  8  last completed byte.
REQ-008 data_valid  output  1  data_out holds an unconsumed byte.
REQ-009 data_ack  input  1  consumer takes data_out; effective only when data_valid=1.
REQ-010 overrun  output  1  one-cycle pulse: a completed byte replaced an unconsumed byte.
REQ-011 frame_err  output  1  one-cycle pulse: a partial byte was discarded.

Function
REQ-012 Byte assembly SHALL be MSB-first: the 1st accepted dibit forms data bits [7:6], the 2nd forms [5:4], the 3rd forms [3:2] and the 4th forms [1:0].
REQ-013 State IDLE SHALL mean no partial byte is held (sym_cnt=0); state COLLECT SHALL mean 1..3 dibits are held.
REQ-014 IDLE: an accepted symbol SHALL be stored as dibit 1, set sym_cnt=1 and move to COLLECT, regardless of sym_first.
REQ-015 COLLECT: an accepted symbol with sym_first=0 SHALL be appended and increment sym_cnt.
REQ-016 COLLECT: an accepted symbol with sym_first=1 SHALL discard the partial byte, pulse frame_err for one cycle, and restart assembly with this symbol as dibit 1 (sym_cnt=1).
REQ-017 When the 4th dibit is accepted, on that same edge the block SHALL load data_out with {held 6 bits, sym_in}, set data_valid=1 and return to IDLE.
REQ-018 Latency: data_valid SHALL be observable in the cycle immediately after the edge that accepts the 4th dibit.
REQ-019 data_valid SHALL stay 1 and data_out SHALL stay stable until an edge with data_ack=1; that edge SHALL clear data_valid unless a byte completes on the same edge.
REQ-020 Byte completes while data_valid=1 and data_ack=0: data_out SHALL be overwritten, data_valid SHALL stay 1 and overrun SHALL pulse for one cycle.
REQ-021 Byte completes on the same edge as data_ack=1: data_out SHALL take the new byte, data_valid SHALL stay 1 and overrun SHALL NOT pulse.
REQ-022 Back-to-back symbols (sym_valid=1 every cycle) SHALL be accepted without stalls, giving one byte per 4 cycles.
REQ-023 sym_valid=0 cycles inside a byte SHALL be tolerated; the partial byte SHALL be held, subject to REQ-026.

Reset
REQ-024 rst=1 SHALL asynchronously force state=IDLE, sym_cnt=0, shift register=0, data_out=8'h00, data_valid=0, overrun=0, frame_err=0 and the timeout counter=0.
REQ-025 Reset asserted mid-byte SHALL discard the partial byte without a frame_err pulse; the first symbol accepted after release SHALL be dibit 1.

Configuration
REQ-026 With macro GATHER_TWO_TIMEOUT_EN defined: while in COLLECT, a counter SHALL count cycles with sym_valid=0 and reset to 0 on each accepted symbol; on reaching TIMEOUT_CYCLES the block SHALL discard the partial byte, return to IDLE and pulse frame_err once.
REQ-027 Without GATHER_TWO_TIMEOUT_EN: no timeout counter SHALL exist, the partial byte SHALL be held indefinitely, and frame_err SHALL pulse only under REQ-016.

Verification
REQ-028 Assemble: dibits 01,10,11,00 on 4 consecutive cycles (sym_first=1 on the first) -> data_out=8'h6C with data_valid=1 in the following cycle.
REQ-029 Overrun: send 8'h6C, hold data_ack=0, then send 8'hA5 -> data_out=8'hA5, data_valid=1, and a single-cycle overrun pulse.
REQ-030 Resync: dibits 11,11 then sym_first=1 with 00,01,10,11 -> frame_err pulses once and data_out=8'h1B.
REQ-031 Ack coincidence: data_ack=1 on the edge where 8'hFF completes while 8'h6C is pending -> data_out=8'hFF, data_valid=1, overrun=0.
REQ-032 Timeout (macro defined, TIMEOUT_CYCLES=64): 2 dibits then 64 idle cycles -> frame_err pulses once; the next 4 dibits 00,00,00,01 -> data_out=8'h01.
REQ-033 Reset: rst asserted after 3 dibits, then released, then 4 dibits 10,10,10,10 -> data_out=8'hAA and no frame_err pulse.
